// File: rtl/io_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : io_input_debouncer
//  Description : Samples the scanner's register-byte bus on a slow tick,
//                debounces every byte independently and reports accepted
//                byte changes as {register index, value} events through a
//                show-ahead FIFO with a valid/ready handshake.
//
//  Build macro : IO_INPUT_DEBOUNCE_EN
//                defined   -> per-byte candidate/counter debounce, a new value
//                             must be seen on DEBOUNCE consecutive ticks.
//                undefined -> any differing byte is accepted on the first
//                             tick; DEBOUNCE is not used for filtering.
//
//  Ports       : Clk          in   system clock, rising edge
//                Rst          in   asynchronous active-high reset
//                inputs       in   BOARDS*8 raw bytes, byte i = [8i+7:8i]
//                stable       out  BOARDS*8 debounced image of inputs
//                event_valid  out  FIFO head valid
//                event_ready  in   consumer accepts the head
//                event_reg    out  register index of the head event
//                event_data   out  byte value of the head event
//                fifo_count   out  occupied FIFO entries
//
//  Revision    : 1.0  initial release
// ============================================================================
module io_input_debouncer #(
    parameter int BOARDS     = 16,
    parameter int SAMPLE_DIV = 1000,
    parameter int DEBOUNCE   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          Clk,
    input  logic                          Rst,
    input  logic [BOARDS*8-1:0]           inputs,
    output logic [BOARDS*8-1:0]           stable,
    output logic                          event_valid,
    input  logic                          event_ready,
    output logic [$clog2(BOARDS)-1:0]     event_reg,
    output logic [7:0]                    event_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_RW = $clog2(BOARDS);
    localparam int c_DW = $clog2(SAMPLE_DIV);
    localparam int c_AW = $clog2(FIFO_DEPTH);

    // Reject parameter sets the datapath cannot represent.
    if (BOARDS < 2 || SAMPLE_DIV < 2 || DEBOUNCE < 1 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("io_input_debouncer: invalid parameter set");
    end

    // ------------------------------------------------------------------
    // Sample tick divider
    // ------------------------------------------------------------------
    logic [c_DW-1:0] r_div;
    logic            w_tick;

    assign w_tick = (r_div == c_DW'(SAMPLE_DIV - 1));

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + c_DW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-byte views of the bus
    // ------------------------------------------------------------------
    logic [7:0]        w_sample [BOARDS];
    logic [7:0]        r_stable [BOARDS];
    logic [BOARDS-1:0] r_pending;
    logic [BOARDS-1:0] w_accept;

    for (genvar gi = 0; gi < BOARDS; gi++) begin : g_byte_map
        assign w_sample[gi]        = inputs[8*gi +: 8];
        assign stable[8*gi +: 8]   = r_stable[gi];
    end

`ifdef IO_INPUT_DEBOUNCE_EN
    // ------------------------------------------------------------------
    // Candidate / consecutive-tick counter per byte
    // ------------------------------------------------------------------
    localparam int c_CW = $clog2(DEBOUNCE + 1);

    logic [7:0]      r_cand     [BOARDS];
    logic [c_CW-1:0] r_cnt      [BOARDS];
    logic [7:0]      w_cand_nxt [BOARDS];
    logic [c_CW-1:0] w_cnt_nxt  [BOARDS];
    logic [c_CW-1:0] w_cnt_inc  [BOARDS];

    always_comb begin
        for (int i = 0; i < BOARDS; i++) begin
            w_accept[i]   = 1'b0;
            w_cand_nxt[i] = r_cand[i];
            w_cnt_nxt[i]  = r_cnt[i];
            w_cnt_inc[i]  = r_cnt[i] + c_CW'(1);
            if (w_tick) begin
                if (w_sample[i] == r_stable[i]) begin
                    // Input fell back to the published value: abandon candidate.
                    w_cnt_nxt[i] = '0;
                end else if (w_sample[i] != r_cand[i]) begin
                    // First sighting of a new value restarts the count at 1.
                    w_cand_nxt[i] = w_sample[i];
                    if (DEBOUNCE == 1) begin
                        w_accept[i] = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = c_CW'(1);
                    end
                end else if (w_cnt_inc[i] == c_CW'(DEBOUNCE)) begin
                    w_accept[i] = 1'b1;
                end else begin
                    w_cnt_nxt[i] = w_cnt_inc[i];
                end
            end
            if (w_accept[i]) begin
                w_cnt_nxt[i] = '0;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < BOARDS; i++) begin
                r_cand[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < BOARDS; i++) begin
                r_cand[i] <= w_cand_nxt[i];
                r_cnt[i]  <= w_cnt_nxt[i];
            end
        end
    end
`else
    // Without filtering, any difference seen on a tick is accepted at once.
    always_comb begin
        for (int i = 0; i < BOARDS; i++) begin
            w_accept[i] = w_tick && (w_sample[i] != r_stable[i]);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Pending arbiter (lowest index wins) and FIFO control
    // ------------------------------------------------------------------
    logic [c_RW-1:0] w_sel;
    logic            w_any;
    logic            w_full;
    logic            w_pop;
    logic            w_push;

    logic [c_RW+7:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;

    always_comb begin
        w_sel = '0;
        for (int i = BOARDS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_sel = c_RW'(i);
            end
        end
    end

    assign w_any  = |r_pending;
    assign w_full = (r_count == (c_AW + 1)'(FIFO_DEPTH));
    assign w_pop  = (r_count != '0) && event_ready;
    // A full FIFO can still take the push when the head leaves this clock.
    assign w_push = w_any && (!w_full || w_pop);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < BOARDS; i++) begin
                r_stable[i] <= '0;
            end
            r_pending <= '0;
        end else begin
            for (int i = 0; i < BOARDS; i++) begin
                // A fresh acceptance wins over the clear, so a re-accept on the
                // push edge produces a further event with the newer value.
                if (w_accept[i]) begin
                    r_stable[i]  <= w_sample[i];
                    r_pending[i] <= 1'b1;
                end else if (w_push && (w_sel == c_RW'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= {w_sel, r_stable[w_sel]};
                r_wr_ptr        <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW + 1)'(1);
                2'b01:   r_count <= r_count - (c_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign event_valid             = (r_count != '0);
    assign {event_reg, event_data} = r_mem[r_rd_ptr];
    assign fifo_count              = r_count;

endmodule
`default_nettype wire

// File: tb/tb_io_input_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_input_debouncer
//  Description : Directed, table-driven bench for io_input_debouncer with
//                SAMPLE_DIV=4, DEBOUNCE=4, FIFO_DEPTH=8, BOARDS=16. Expected
//                values follow the build: with IO_INPUT_DEBOUNCE_EN a value is
//                accepted on its 4th tick, otherwise on its first.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_io_input_debouncer;

    localparam int BOARDS     = 16;
    localparam int SAMPLE_DIV = 4;
    localparam int DEBOUNCE   = 4;
    localparam int FIFO_DEPTH = 8;
`ifdef IO_INPUT_DEBOUNCE_EN
    localparam int DB_EFF = DEBOUNCE;
`else
    localparam int DB_EFF = 1;
`endif

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic [127:0] inputs;
    logic [127:0] stable;
    logic         event_valid;
    logic         event_ready;
    logic [3:0]   event_reg;
    logic [7:0]   event_data;
    logic [3:0]   fifo_count;

    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    logic [127:0] exp_img;

    always #5 Clk = ~Clk;

    io_input_debouncer #(
        .BOARDS     (BOARDS),
        .SAMPLE_DIV (SAMPLE_DIV),
        .DEBOUNCE   (DEBOUNCE),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .inputs      (inputs),
        .stable      (stable),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_reg   (event_reg),
        .event_data  (event_data),
        .fifo_count  (fifo_count)
    );

    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] val;
        logic [7:0] st4;   // stable byte expected with a 4-tick filter
        logic       ev4;
        logic [7:0] st1;   // stable byte expected with immediate acceptance
        logic       ev1;
    } vec_t;

    vec_t tbl [12];
    int   bp  [10];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [3:0] r, input logic [7:0] d);
        check({tag, " valid"}, event_valid, 1'b1);
        check({tag, " reg"},   event_reg,   r);
        check({tag, " data"},  event_data,  d);
    endtask

    // One clock; the phase counter mirrors the divider (tick edges are multiples of 4).
    task automatic step();
        @(posedge Clk);
        if (!Rst) ecnt++;
        #1;
    endtask

    task automatic run_to_tick();
        do step(); while (ecnt % SAMPLE_DIV != 0);
    endtask

    task automatic run_ticks(input int n);
        for (int k = 0; k < n; k++) run_to_tick();
    endtask

    task automatic set_in(input int i, input logic [7:0] v);
        inputs[8*i +: 8] = v;
    endtask

    initial begin
        //            idx  val    st4   ev4   st1   ev1
        tbl[0]  = '{4'd3, 8'h5A, 8'h00, 1'b0, 8'h5A, 1'b1};
        tbl[1]  = '{4'd3, 8'h5A, 8'h00, 1'b0, 8'h5A, 1'b0};
        tbl[2]  = '{4'd3, 8'h5A, 8'h00, 1'b0, 8'h5A, 1'b0};
        tbl[3]  = '{4'd3, 8'h5A, 8'h5A, 1'b1, 8'h5A, 1'b0};
        tbl[4]  = '{4'd1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b1};
        tbl[5]  = '{4'd1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0};
        tbl[6]  = '{4'd1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0};
        tbl[7]  = '{4'd1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1};
        tbl[8]  = '{4'd1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b1};
        tbl[9]  = '{4'd1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0};
        tbl[10] = '{4'd1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0};
        tbl[11] = '{4'd1, 8'h01, 8'h01, 1'b1, 8'h01, 1'b0};
        bp = '{0, 2, 3, 4, 5, 6, 7, 8, 9, 12};

        // ---------------- reset with all-ones inputs ----------------
        inputs      = '1;
        event_ready = 1'b0;
        exp_img     = '0;
        step();
        step();
        check("rst stable", stable, '0);
        check("rst valid", event_valid, 1'b0);
        check("rst count", fifo_count, 4'd0);
        check("rst reg", event_reg, 4'd0);
        check("rst data", event_data, 8'd0);
        Rst  = 1'b0;
        ecnt = 0;
        run_ticks(DB_EFF - 1);
        check("pre-accept stable", stable, '0);
        run_to_tick();
        check("accept all ones", stable, '1);
        for (int k = 0; k < 10; k++) step();
        check("full count", fifo_count, 4'd8);
        check_head("full head", 4'd0, 8'hFF);

        // ---------------- asynchronous reset mid-operation ----------------
        #2;
        Rst = 1'b1;
        #1;
        check("async rst stable", stable, '0);
        check("async rst count", fifo_count, 4'd0);
        check("async rst valid", event_valid, 1'b0);
        inputs = '0;
        step();
        step();
        Rst  = 1'b0;
        ecnt = 0;

        // ---------------- table: clean change, glitch, re-accept ----------------
        event_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            vec_t       v;
            logic [7:0] est;
            logic       eev;
            v   = tbl[k];
            est = (DB_EFF == 1) ? v.st1 : v.st4;
            eev = (DB_EFF == 1) ? v.ev1 : v.ev4;
            set_in(int'(v.idx), v.val);
            run_to_tick();
            exp_img[8*v.idx +: 8] = est;
            check($sformatf("vec%0d stable", k), stable, exp_img);
            step();
            check($sformatf("vec%0d valid", k), event_valid, eev);
            check($sformatf("vec%0d count", k), fifo_count, {3'd0, eev});
            if (eev) begin
                check($sformatf("vec%0d reg", k), event_reg, v.idx);
                check($sformatf("vec%0d data", k), event_data, est);
            end
        end

        // ---------------- ordering: bytes 5 and 2 on the same tick ----------------
        event_ready = 1'b0;
        set_in(5, 8'h25);
        set_in(2, 8'h52);
        run_ticks(DB_EFF);
        exp_img[8*5 +: 8] = 8'h25;
        exp_img[8*2 +: 8] = 8'h52;
        check("order stable", stable, exp_img);
        step();
        check("order count1", fifo_count, 4'd1);
        check_head("order first", 4'd2, 8'h52);
        step();
        check("order count2", fifo_count, 4'd2);
        event_ready = 1'b1;
        check_head("order head", 4'd2, 8'h52);
        step();
        check_head("order second", 4'd5, 8'h25);
        check("order count3", fifo_count, 4'd1);
        step();
        check("order drained", event_valid, 1'b0);

        // ---------------- backpressure: 10 changes into 8 entries ----------------
        event_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            set_in(bp[k], 8'(8'hC0 + bp[k]));
            exp_img[8*bp[k] +: 8] = 8'(8'hC0 + bp[k]);
        end
        run_ticks(DB_EFF);
        check("bp stable", stable, exp_img);
        for (int k = 0; k < 12; k++) step();
        check("bp count full", fifo_count, 4'd8);
        check_head("bp head", 4'd0, 8'hC0);
        // Byte 9 is still pending; change it again while stalled.
        set_in(9, 8'h3C);
        run_ticks(DB_EFF);
        exp_img[8*9 +: 8] = 8'h3C;
        check("bp re-accept stable", stable, exp_img);
        check("bp count held", fifo_count, 4'd8);
        event_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check_head($sformatf("drain%0d", k), 4'(bp[k]),
                       (bp[k] == 9) ? 8'h3C : 8'(8'hC0 + bp[k]));
            step();
        end
        check("bp drained valid", event_valid, 1'b0);
        check("bp drained count", fifo_count, 4'd0);
        step();
        step();
        check("bp no extra event", event_valid, 1'b0);

        // ---------------- byte 0 to 0xFF ----------------
        set_in(0, 8'hFF);
        run_ticks(DB_EFF);
        exp_img[7:0] = 8'hFF;
        check("b0 stable", stable, exp_img);
        step();
        check_head("b0 event", 4'd0, 8'hFF);
        check("b0 count", fifo_count, 4'd1);
        step();
        check("b0 popped", fifo_count, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/io_input_debouncer.md
# io_input_debouncer

Downstream consumer of the I/O register scanner's `inputs` bus, which holds one byte per board register. It samples the bus at a slow tick and debounces each register byte independently. When a byte has stayed at a new value long enough, it publishes the byte as a change event through a small FIFO with a valid/ready handshake, so the emulator core sees clean key and switch transitions instead of raw scanned levels.

## Interface
- `BOARDS`, 16: number of 8-bit input registers on the bus.
- `SAMPLE_DIV`, 1000: clocks per sample tick; minimum 2.
- `DEBOUNCE`, 4: consecutive ticks a new value must hold before it is accepted; minimum 1.
- `FIFO_DEPTH`, 8: event FIFO entries; power of two, minimum 2.

Ports:
- `Clk`  in  1  single system clock, rising edge.
- `Rst`  in  1  asynchronous, active-high reset.
- `inputs`  in  BOARDS*8  raw register bytes from the scanner; byte i is bits [8i+7:8i]; synchronous to `Clk`.
- `stable`  out  BOARDS*8  debounced image of `inputs`.
- `event_valid`  out  1  FIFO head is valid.
- `event_ready`  in  1  consumer accepts the head.
- `event_reg`  out  $clog2(BOARDS)  register index of the head event.
- `event_data`  out  8  byte value carried by the head event.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.

## Operation
- Tick divider counts 0..SAMPLE_DIV-1 and wraps. `tick` is asserted for the one clock in which the count equals SAMPLE_DIV-1.
- Each byte i has a candidate byte `cand[i]` and a counter `cnt[i]`. On each tick, with `s` being the current byte i of `inputs`:
  - If `s == stable[i]`: `cnt <= 0`.
  - Else if `s != cand[i]`: `cand <= s` and `cnt <= 1`. If DEBOUNCE==1, the byte is accepted immediately.
  - Else: `cnt <= cnt+1`. When `cnt+1 == DEBOUNCE`, the byte is accepted.
- Accept means: `stable[i] <= s`, `pending[i] <= 1`, `cnt <= 0`.
- Pending arbiter: each clock, the lowest-index set `pending` bit is pushed into the FIFO as {i, `stable[i]`}, provided the FIFO is not full or a pop occurs in the same clock. That bit is then cleared.
- If a byte re-accepts on the same edge its pending bit is pushed, the set takes priority and the bit stays 1. Repeated changes while pending coalesce into one event that carries the latest `stable` value at push time.
- Pop occurs when `event_valid && event_ready`. The FIFO is show-ahead: the head is visible on `event_reg`/`event_data` while `event_valid` is high.
- No event is ever lost. Backpressure holds bytes in `pending`, and tick processing continues during backpressure.
- `event_reg`/`event_data` are don't-care while `event_valid` is 0.

## Timing
- Reset values: `stable`=0, `cand`=0, `cnt`=0, `pending`=0, divider=0, FIFO empty, `event_valid`=0, `fifo_count`=0, `event_reg`=0, `event_data`=0.
- When `Rst` is asserted mid-operation, all state clears immediately. Queued and pending events are discarded.
- Acceptance latency: a new value that is present at DEBOUNCE consecutive ticks is written to `stable` on the edge of the DEBOUNCE-th tick, edge T.
- With the FIFO empty and no lower-index byte pending, the push happens at edge T+1 and `event_valid` is high after T+1.
- `fifo_count` updates on the same edge as the push or pop. A simultaneous push and pop leaves it unchanged.
- Push into a full FIFO is permitted only in a clock that also pops.

## Configuration
- `IO_INPUT_DEBOUNCE_EN` defined: behaviour as above.
- `IO_INPUT_DEBOUNCE_EN` undefined:
  - `cand` and `cnt` are removed and `DEBOUNCE` is ignored.
  - On every tick, any byte with `s != stable[i]` is accepted at once.
  - Event path and timing from T onward are unchanged.

## Test plan
- Reset:
  - Assert `Rst` with `inputs`=all ones -> `stable`=0, `event_valid`=0, `fifo_count`=0.
  - Release `Rst` -> byte changes are accepted after DEBOUNCE ticks.
- Clean change (SAMPLE_DIV=4, DEBOUNCE=4):
  - Stimulus: byte 3 goes from 0x00 to 0x5A and holds.
  - Required response: `stable[3]` becomes 0x5A on the 4th tick edge, then exactly one event {3, 0x5A} with `event_valid` high one clock later.
- Glitch: byte 1 set to 0x01 for 3 ticks, then back to 0x00 -> no event, `stable` unchanged, `cnt` returns to 0.
- Ordering: bytes 5 and 2 accepted on the same tick -> events {2,…} then {5,…} on consecutive clocks, `fifo_count` reaching 2.
- Backpressure (FIFO_DEPTH=8, `event_ready`=0):
  - Stimulus: 10 bytes change and accept.
  - While `event_ready` stays 0: `fifo_count`=8 and 2 bits remain pending.
  - On raising `event_ready`: all 10 events are drained in index order with none lost.
  - Byte 9 changes again before its push -> a single event carrying the latest value.
- Macro off:
  - Stimulus: byte 0 changes to 0xFF.
  - Required response: accepted on the first tick, event {0, 0xFF} visible one clock later.
